// File: rtl/approx_err_pkg.sv
// approx_err_pkg
// Shared definitions for the approximate-datapath error monitor:
//   - default width constants for every instance parameter
//   - FSM state encoding
//   - result-beat record at default widths
//   - saturating add helpers (unsigned and signed), evaluated on a wide
//     internal word and clamped to a caller-supplied accumulator width
package approx_err_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_N_CH      = 2;
  localparam int DEF_ER_THRESH = 8;
  localparam int DEF_CNT_W     = 32;
  localparam int DEF_ACC_W     = 64;
  localparam int DEF_SQ_W      = 96;

  // Working width of the saturating helpers; accumulators must be narrower.
  localparam int SAT_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  // One channel's report at default widths; err_sum holds two's complement.
  typedef struct packed {
    logic [DEF_ACC_W-1:0] err_sum;
    logic [DEF_ACC_W-1:0] abs_sum;
    logic [DEF_SQ_W-1:0]  sq_sum;
    logic [DEF_CNT_W-1:0] nz_cnt;
    logic [DEF_CNT_W-1:0] thr_cnt;
    logic                 ovf;
  } result_t;

  // Unsigned add clamped to 2^w-1. Returns {saturated, sum}.
  function automatic logic [SAT_W:0] sat_add_u(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = {1'b0, {SAT_W{1'b1}} >> (SAT_W - w)};
    if (sum > lim) begin
      return {1'b1, lim[SAT_W-1:0]};
    end else begin
      return {1'b0, sum[SAT_W-1:0]};
    end
  endfunction

  // Signed add clamped to [-2^(w-1), 2^(w-1)-1]. Returns {saturated, sum}.
  function automatic logic [SAT_W:0] sat_add_s(input logic signed [SAT_W-1:0] a,
                                               input logic signed [SAT_W-1:0] b,
                                               input int unsigned             w);
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = a + b;
    hi  = $signed({SAT_W{1'b1}} >> (SAT_W - w + 32'd1));
    lo  = ~hi;
    if (sum > hi) begin
      return {1'b1, hi};
    end else if (sum < lo) begin
      return {1'b1, lo};
    end else begin
      return {1'b0, sum};
    end
  endfunction

endpackage

// File: rtl/approx_err_monitor_if.sv
// approx_err_monitor_if
// Control, sample-input stream and result-beat stream of the error monitor.
//   control : start, clr, num_samples (host -> engine); busy, done (engine -> host)
//   input   : in_valid, approx, exact (host -> engine); in_ready (engine -> host)
//   result  : out_valid, out_ch, out_* fields (engine -> host); out_ready (host -> engine)
// modport master = host side, modport slave = engine side.
interface approx_err_monitor_if #(
  parameter int DATA_W = 32,
  parameter int N_CH   = 2,
  parameter int CNT_W  = 32,
  parameter int ACC_W  = 64,
  parameter int SQ_W   = 96
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                     start;
  logic                     clr;
  logic [CNT_W-1:0]         num_samples;
  logic                     in_valid;
  logic                     in_ready;
  logic [N_CH*DATA_W-1:0]   approx;
  logic [N_CH*DATA_W-1:0]   exact;
  logic                     busy;
  logic                     done;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH_W-1:0]          out_ch;
  logic [ACC_W-1:0]         out_err_sum;
  logic [ACC_W-1:0]         out_abs_sum;
  logic [SQ_W-1:0]          out_sq_sum;
  logic [CNT_W-1:0]         out_nz_cnt;
  logic [CNT_W-1:0]         out_thr_cnt;
  logic [CNT_W-1:0]         out_samples;
  logic                     out_ovf;

  modport master (
    output start, clr, num_samples, in_valid, approx, exact, out_ready,
    input  in_ready, busy, done, out_valid, out_ch, out_err_sum, out_abs_sum,
           out_sq_sum, out_nz_cnt, out_thr_cnt, out_samples, out_ovf
  );

  modport slave (
    input  start, clr, num_samples, in_valid, approx, exact, out_ready,
    output in_ready, busy, done, out_valid, out_ch, out_err_sum, out_abs_sum,
           out_sq_sum, out_nz_cnt, out_thr_cnt, out_samples, out_ovf
  );
endinterface

// File: rtl/approx_err_lane.sv
// approx_err_lane
// One channel of the error monitor: two-stage difference / accumulate.
//   stage 1: err = approx - exact (DATA_W+1 bits), |err|, nz and thr flags
//   stage 2: err^2 and saturating accumulation of all statistics
// Ports: clk, rst (async, high); clear (sync flush of pipeline and sums);
//        acc_en (sample accepted this cycle); approx/exact (one channel);
//        err_sum, abs_sum, sq_sum, nz_cnt, thr_cnt, ovf (registered totals).
module approx_err_lane import approx_err_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ER_THRESH = DEF_ER_THRESH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int SQ_W      = DEF_SQ_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] approx,
  input  logic [DATA_W-1:0] exact,
  output logic [ACC_W-1:0]  err_sum,
  output logic [ACC_W-1:0]  abs_sum,
  output logic [SQ_W-1:0]   sq_sum,
  output logic [CNT_W-1:0]  nz_cnt,
  output logic [CNT_W-1:0]  thr_cnt,
  output logic              ovf
);
  localparam int EW = DATA_W + 1;
  localparam int PW = 2 * DATA_W + 2;

  logic signed [EW-1:0] err_s;
  logic [EW-1:0]        abs_s;
  logic                 nz_s;
  logic                 thr_s;

  logic                 v1_r;
  logic signed [EW-1:0] err1_r;
  logic [EW-1:0]        abs1_r;
  logic                 nz1_r;
  logic                 thr1_r;

  logic signed [PW-1:0] err1_x_s;
  logic [PW-1:0]        sq_s;
  logic [SAT_W:0]       err_add_s;
  logic [SAT_W:0]       abs_add_s;
  logic [SAT_W:0]       sq_add_s;

  logic [ACC_W-1:0]     err_sum_r;
  logic [ACC_W-1:0]     abs_sum_r;
  logic [SQ_W-1:0]      sq_sum_r;
  logic [CNT_W-1:0]     nz_cnt_r;
  logic [CNT_W-1:0]     thr_cnt_r;
  logic                 ovf_r;

  // Stage-1 arithmetic: one extra bit keeps the difference from wrapping.
  always_comb begin
    err_s = $signed({approx[DATA_W-1], approx}) - $signed({exact[DATA_W-1], exact});
    if (err_s[EW-1]) begin
      abs_s = $unsigned(-err_s);
    end else begin
      abs_s = $unsigned(err_s);
    end
    nz_s  = (approx != exact);
    thr_s = (approx[DATA_W-1:ER_THRESH] != exact[DATA_W-1:ER_THRESH]);
  end

  // Stage-1 register; clear drops any sample in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r   <= 1'b0;
      err1_r <= {EW{1'b0}};
      abs1_r <= {EW{1'b0}};
      nz1_r  <= 1'b0;
      thr1_r <= 1'b0;
    end else if (clear) begin
      v1_r   <= 1'b0;
      err1_r <= {EW{1'b0}};
      abs1_r <= {EW{1'b0}};
      nz1_r  <= 1'b0;
      thr1_r <= 1'b0;
    end else begin
      v1_r <= acc_en;
      if (acc_en) begin
        err1_r <= err_s;
        abs1_r <= abs_s;
        nz1_r  <= nz_s;
        thr1_r <= thr_s;
      end
    end
  end

  // Stage-2 square and saturating sums on the wide helper word.
  always_comb begin
    err1_x_s  = {{(PW-EW){err1_r[EW-1]}}, err1_r};
    sq_s      = $unsigned(err1_x_s * err1_x_s);
    err_add_s = sat_add_s({{(SAT_W-ACC_W){err_sum_r[ACC_W-1]}}, err_sum_r},
                          {{(SAT_W-EW){err1_r[EW-1]}}, err1_r}, ACC_W);
    abs_add_s = sat_add_u({{(SAT_W-ACC_W){1'b0}}, abs_sum_r},
                          {{(SAT_W-EW){1'b0}}, abs1_r}, ACC_W);
    sq_add_s  = sat_add_u({{(SAT_W-SQ_W){1'b0}}, sq_sum_r},
                          {{(SAT_W-PW){1'b0}}, sq_s}, SQ_W);
  end

  // Stage-2 accumulators and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sum_r <= {ACC_W{1'b0}};
      abs_sum_r <= {ACC_W{1'b0}};
      sq_sum_r  <= {SQ_W{1'b0}};
      nz_cnt_r  <= {CNT_W{1'b0}};
      thr_cnt_r <= {CNT_W{1'b0}};
      ovf_r     <= 1'b0;
    end else if (clear) begin
      err_sum_r <= {ACC_W{1'b0}};
      abs_sum_r <= {ACC_W{1'b0}};
      sq_sum_r  <= {SQ_W{1'b0}};
      nz_cnt_r  <= {CNT_W{1'b0}};
      thr_cnt_r <= {CNT_W{1'b0}};
      ovf_r     <= 1'b0;
    end else if (v1_r) begin
      err_sum_r <= err_add_s[ACC_W-1:0];
      abs_sum_r <= abs_add_s[ACC_W-1:0];
      sq_sum_r  <= sq_add_s[SQ_W-1:0];
      nz_cnt_r  <= nz_cnt_r + {{(CNT_W-1){1'b0}}, nz1_r};
      thr_cnt_r <= thr_cnt_r + {{(CNT_W-1){1'b0}}, thr1_r};
      ovf_r     <= ovf_r | err_add_s[SAT_W] | abs_add_s[SAT_W] | sq_add_s[SAT_W];
    end
  end

  assign err_sum = err_sum_r;
  assign abs_sum = abs_sum_r;
  assign sq_sum  = sq_sum_r;
  assign nz_cnt  = nz_cnt_r;
  assign thr_cnt = thr_cnt_r;
  assign ovf     = ovf_r;
endmodule

// File: rtl/approx_err_monitor.sv
// approx_err_monitor
// Streaming error-statistics engine. Collects num_samples approx/exact pairs
// per window on N_CH channels, then emits one result beat per channel.
// Ports: clk; rst (async, high); bus (approx_err_monitor_if.slave) carrying
//        control (start/clr/num_samples/busy/done), the sample stream
//        (in_valid/in_ready/approx/exact) and the result stream
//        (out_valid/out_ready/out_ch/out_* statistics).
module approx_err_monitor import approx_err_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int N_CH      = DEF_N_CH,
  parameter int ER_THRESH = DEF_ER_THRESH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int SQ_W      = DEF_SQ_W
) (
  input logic               clk,
  input logic               rst,
  approx_err_monitor_if.slave bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_CH - 1);
  localparam logic [CH_W-1:0]  CH_ONE  = {{(CH_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_r;
  state_e           state_nx;
  logic [CNT_W-1:0] num_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CH_W-1:0]  out_ch_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             done_r;
  logic             done_nx;
  logic             accept_s;
  logic             beat_s;
  logic             open_s;
  logic             lane_clr_s;

  logic [ACC_W-1:0] err_sum_s [N_CH];
  logic [ACC_W-1:0] abs_sum_s [N_CH];
  logic [SQ_W-1:0]  sq_sum_s  [N_CH];
  logic [CNT_W-1:0] nz_cnt_s  [N_CH];
  logic [CNT_W-1:0] thr_cnt_s [N_CH];
  logic             ovf_s     [N_CH];

  assign accept_s   = bus.in_valid & in_ready_r;
  assign beat_s     = out_valid_r & bus.out_ready;
  // A window opens only from IDLE and only when no abort is pending.
  assign open_s     = (state_r == ST_IDLE) & bus.start & ~bus.clr;
  assign lane_clr_s = bus.clr | open_s;

  // Next-state and done-pulse decode; abort overrides every state.
  always_comb begin
    state_nx = state_r;
    done_nx  = 1'b0;
    if (bus.clr) begin
      state_nx = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.num_samples == {CNT_W{1'b0}}) begin
              state_nx = ST_REPORT;
            end else begin
              state_nx = ST_ACCUM;
            end
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (accept_s && (cnt_r == num_r - CNT_ONE)) begin
            state_nx = ST_DRAIN;
          end else begin
            state_nx = ST_ACCUM;
          end
        end
        ST_DRAIN: begin
          state_nx = ST_REPORT;
        end
        ST_REPORT: begin
          if (beat_s && (out_ch_r == LAST_CH)) begin
            state_nx = ST_IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = ST_REPORT;
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // State, sample counter, report channel and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      num_r       <= {CNT_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      out_ch_r    <= {CH_W{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nx;
      // ACCUM is only ever occupied while accepted < num_samples.
      in_ready_r  <= (state_nx == ST_ACCUM);
      out_valid_r <= (state_nx == ST_REPORT);
      busy_r      <= (state_nx != ST_IDLE);
      done_r      <= done_nx;
      if (open_s) begin
        num_r <= bus.num_samples;
      end
      if (lane_clr_s) begin
        cnt_r    <= {CNT_W{1'b0}};
        out_ch_r <= {CH_W{1'b0}};
      end else begin
        if (accept_s) begin
          cnt_r <= cnt_r + CNT_ONE;
        end
        if (beat_s) begin
          out_ch_r <= (out_ch_r == LAST_CH) ? {CH_W{1'b0}} : out_ch_r + CH_ONE;
        end
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    approx_err_lane #(
      .DATA_W(DATA_W), .ER_THRESH(ER_THRESH), .CNT_W(CNT_W),
      .ACC_W(ACC_W), .SQ_W(SQ_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clear   (lane_clr_s),
      .acc_en  (accept_s),
      .approx  (bus.approx[c*DATA_W +: DATA_W]),
      .exact   (bus.exact[c*DATA_W +: DATA_W]),
      .err_sum (err_sum_s[c]),
      .abs_sum (abs_sum_s[c]),
      .sq_sum  (sq_sum_s[c]),
      .nz_cnt  (nz_cnt_s[c]),
      .thr_cnt (thr_cnt_s[c]),
      .ovf     (ovf_s[c])
    );
  end

  // Report mux selects among registered lane totals by the registered channel
  // index, so beats hold steady while the consumer stalls.
  assign bus.in_ready    = in_ready_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_ch      = out_ch_r;
  assign bus.out_err_sum = err_sum_s[out_ch_r];
  assign bus.out_abs_sum = abs_sum_s[out_ch_r];
  assign bus.out_sq_sum  = sq_sum_s[out_ch_r];
  assign bus.out_nz_cnt  = nz_cnt_s[out_ch_r];
  assign bus.out_thr_cnt = thr_cnt_s[out_ch_r];
  assign bus.out_samples = cnt_r;
  assign bus.out_ovf     = ovf_s[out_ch_r];
endmodule

// File: doc/approx_err_monitor.md
# approx_err_monitor

Synthesizable, streaming error-statistics engine for approximate-datapath evaluation. It accepts per-sample pairs of approximate and exact results on N_CH parallel channels over a programmable window. Per channel it accumulates the error sum, absolute-error sum, squared-error sum, nonzero-error count and thresholded-mismatch count. At window end it reports one result beat per channel over a valid/ready port, so mean, variance, MSE, ER0 and ER1 can be computed on-chip or by a host instead of in a behavioural bench. It sits beside an approximate kernel (e.g. an ARF variant) and its exact reference, fed from the same input stream.

## Interface
- DATA_W, 32, width of each signed result word
- N_CH, 2, number of independent output channels compared
- ER_THRESH, 8, LSB index of the high field used for thresholded mismatch (bits DATA_W-1:ER_THRESH)
- CNT_W, 32, sample-counter width
- ACC_W, 64, width of signed error-sum and unsigned abs-sum accumulators
- SQ_W, 96, width of unsigned squared-error accumulator (must be ≥ 2*DATA_W+2)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin window; num_samples latched; ignored unless IDLE
- clr  in  1  synchronous abort to IDLE, accumulators cleared
- num_samples  in  CNT_W  window length in samples
- in_valid  in  1  sample pair valid
- in_ready  out  1  engine accepts sample
- approx  in  N_CH*DATA_W  approximate results, channel c at [c*DATA_W +: DATA_W]
- exact  in  N_CH*DATA_W  exact results, same packing
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after last result beat accepted
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts beat
- out_ch  out  $clog2(N_CH) (min 1)  channel index of beat
- out_err_sum  out  ACC_W  signed Σ(approx−exact)
- out_abs_sum  out  ACC_W  Σ|approx−exact|
- out_sq_sum  out  SQ_W  Σ(approx−exact)²
- out_nz_cnt  out  CNT_W  samples with approx ≠ exact
- out_thr_cnt  out  CNT_W  samples with high fields differing
- out_samples  out  CNT_W  samples accumulated
- out_ovf  out  1  sticky: any accumulator of this channel saturated

## Operation
- FSM states: IDLE, ACCUM, DRAIN, REPORT.
- IDLE: start → ACCUM, latch num_samples, clear accumulators/counters/ovf. If num_samples == 0 → REPORT directly (all-zero beats).
- ACCUM: in_ready = 1 while accepted < num_samples. A handshake (in_valid & in_ready) accepts one pair for all channels. When the last sample is accepted → DRAIN.
- DRAIN: one cycle for pipeline stage 2 to commit, then → REPORT.
- REPORT: out_valid = 1, out_ch starts at 0. Each out_valid & out_ready advances out_ch. Acceptance of the beat for ch N_CH−1 → IDLE with done pulse.
- Per sample, per channel: err = signed(approx) − signed(exact) at DATA_W+1 bits, never wraps. abs = |err| at DATA_W+1 bits unsigned. sq = err² at 2*DATA_W+2 bits.
- nz flag = (approx ≠ exact). thr flag = (approx[DATA_W−1:ER_THRESH] ≠ exact[DATA_W−1:ER_THRESH]).
- Accumulators saturate (err_sum at signed ACC_W limits, others at all-ones) and set the channel's sticky ovf. Counters never exceed num_samples.
- clr in any state → IDLE next cycle, accumulators zero, no done, pipeline contents discarded. clr and start in the same cycle: clr wins.
- start outside IDLE is ignored. Inputs presented while in_ready = 0 are not consumed.

## Timing
- Reset values: in_ready 0, busy 0, done 0, out_valid 0, out_ch 0, all sums/counts 0, out_ovf 0, state IDLE.
- Stage 1 (cycle after accept): err, abs and flags registered. Stage 2 (next cycle): sq computed and accumulated.
- Last accept at cycle t → DRAIN at t+1 → out_valid at t+2 (with num_samples=1, start at t0 gives earliest out_valid at t0+3).
- Result outputs are stable while out_valid & !out_ready. Outputs are registered, with no combinational in→out paths.
- in_ready depends only on state and counter, never on in_valid.
- rst mid-window: immediate return to reset values, no partial report.

## Structure
- Package approx_err_pkg: state enum, default width constants, result-beat struct (err_sum, abs_sum, sq_sum, nz_cnt, thr_cnt, ovf) and a saturating-add function.
- Sub-module approx_err_lane: per-channel two-stage diff/accumulate, generated N_CH times. Top holds the FSM, sample counter and report mux.

## Test plan
- Defaults, num_samples=4. ch0 approx=exact=100. ch1 exact=0x10, approx=0x13. Expected: ch0 all zero. ch1 err_sum 12, abs 12, sq 36, nz 4, thr 0, samples 4.
- One sample, ch0 approx=−5, exact=5. Expected: err_sum −10, abs 10, sq 100, nz 1, thr 1.
- ch0 approx=0x7FFFFFFF, exact=0x80000000. Expected: err_sum 4294967295, sq 18446744065119617025, no ovf.
- Random in_valid gaps, out_ready held low 5 cycles in REPORT. Expected: beats stable, out_ch 0 then 1, one done pulse, totals equal the reference model.
- num_samples=0. Expected: two zero beats and done. Separately, clr after 2 of 8 samples: IDLE, no out_valid. Separately, rst asserted mid-REPORT: all outputs 0 asynchronously.
- ACC_W=36, 20 samples of err=+2^31. Expected: err_sum saturates at 2^35−1, out_ovf=1, nz 20.
